// File: rtl/lpm_mem_responder.sv
// Lookup-table memory responder.
// After reset the table is cleared one word per cycle (INIT), then lookup
// requests are served in order through a fixed-latency read pipeline and a
// response FIFO. Table writes arrive on a separate load port.
// Ports:
//   CLK, nRST                               clock, async active-low reset
//   ifc_req_ena/_v/_rdy                     lookup request (key low AWIDTH bits index)
//   ifc_res_value/_rdy                      head-of-queue response word and its valid
//   ifc_res_accept_ena/_rdy                 consume head response
//   load_write_ena/_addr/_data/_rdy         table write, ready only in RUN
module lpm_mem_responder #(
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ifc_req_ena,
  input  logic [31:0]       ifc_req_v,
  output logic              ifc_req_rdy,
  output logic [31:0]       ifc_res_value,
  output logic              ifc_res_value_rdy,
  input  logic              ifc_res_accept_ena,
  output logic              ifc_res_accept_rdy,
  input  logic              load_write_ena,
  input  logic [AWIDTH-1:0] load_write_addr,
  input  logic [31:0]       load_write_data,
  output logic              load_write_rdy
);

  localparam int unsigned WORDS = 1 << AWIDTH;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;

  logic              tbl_we;
  logic [AWIDTH-1:0] tbl_wa;
  logic [31:0]       tbl_wd;
  logic [31:0]       tbl [WORDS];
  logic [31:0]       rd_data;

  logic              accept;
  logic              deq;
  logic              enq_v;
  logic [31:0]       enq_d;

  logic [CW-1:0]     occ_q;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic              fifo_ne;

  // Key bits above the index are intentionally ignored.
  logic unused_key;
  assign unused_key = &{1'b0, ifc_req_v[31:AWIDTH]};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State and clear-pointer register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, table write port selection and ready outputs.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    tbl_we         = 1'b0;
    tbl_wa         = ptr_q;
    tbl_wd         = 32'd0;
    ifc_req_rdy    = 1'b0;
    load_write_rdy = 1'b0;
    case (state_q)
      INIT: begin
        tbl_we = 1'b1;
        ptr_d  = ptr_q + AWIDTH'(1);
        if (ptr_q == AWIDTH'(WORDS - 1)) state_d = RUN;
      end
      RUN: begin
        load_write_rdy = 1'b1;
        ifc_req_rdy    = (occ_q < CW'(DEPTH));
        if (load_write_ena) begin
          tbl_we = 1'b1;
          tbl_wa = load_write_addr;
          tbl_wd = load_write_data;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Table storage; a same-cycle read sees the pre-write contents.
  always_ff @(posedge CLK) begin
    if (tbl_we) tbl[tbl_wa] <= tbl_wd;
  end

  assign rd_data = tbl[ifc_req_v[AWIDTH-1:0]];
  assign accept  = ifc_req_ena & ifc_req_rdy;
  assign fifo_ne = (fifo_cnt_q != '0);
  assign deq     = ifc_res_accept_ena & fifo_ne;

  // Read pipeline: the last stage feeds the FIFO write, so the FIFO sees
  // the word LATENCY edges after the accept edge minus one register.
  if (LATENCY == 1) begin : g_nopipe
    assign enq_v = accept;
    assign enq_d = rd_data;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    logic [31:0]        pd_q [LATENCY-1];

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        pv_q <= '0;
        for (int unsigned i = 0; i < LATENCY - 1; i++) pd_q[i] <= 32'd0;
      end else begin
        pv_q[0] <= accept;
        pd_q[0] <= rd_data;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
          pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign enq_v = pv_q[LATENCY-2];
    assign enq_d = pd_q[LATENCY-2];
  end

  // Occupancy: in-flight plus queued; bounds acceptance so the FIFO never overflows.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ_q <= '0;
    end else begin
      case ({accept, deq})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Response FIFO with pointers wrapping modulo DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_mem[i] <= 32'd0;
    end else begin
      if (enq_v) begin
        fifo_mem[wr_ptr_q] <= enq_d;
        wr_ptr_q           <= ptr_next(wr_ptr_q);
      end
      if (deq) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({enq_v, deq})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign ifc_res_value_rdy  = fifo_ne;
  assign ifc_res_accept_rdy = fifo_ne;
  assign ifc_res_value      = fifo_ne ? fifo_mem[rd_ptr_q] : 32'd0;

endmodule

// File: doc/lpm_mem_responder.md
LPM_MEM_RESPONDER -- requirements
Module: lpm_mem_responder

Interface
REQ-001 Parameter AWIDTH, default 8: table index width; the table holds 2^AWIDTH words of 32 bits.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to the response entering the response FIFO; legal range 1..4.
REQ-003 Parameter DEPTH, default 4: maximum outstanding plus queued responses; legal range 2..8.
REQ-004 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 nRST  in  1  asynchronous, active-low reset.
REQ-006 ifc$req__ENA  in  1  lookup request strobe; legal only while ifc$req__RDY=1.
REQ-007 ifc$req$v  in  32  lookup key; bits [AWIDTH-1:0] index the table, upper bits are ignored.
REQ-008 ifc$req__RDY  out  1  responder can accept a request this cycle.
REQ-009 ifc$resValue  out  32  head-of-queue response word.
REQ-010 ifc$resValue__RDY  out  1  ifc$resValue is valid.
REQ-011 ifc$resAccept__ENA  in  1  consume the head response; legal only while ifc$resAccept__RDY=1.
REQ-012 ifc$resAccept__RDY  out  1  a response is available to consume.
REQ-013 load$write__ENA  in  1  table write strobe; legal only while load$write__RDY=1.
REQ-014 load$write$addr  in  AWIDTH  table write address.
REQ-015 load$write$data  in  32  table write data.
REQ-016 load$write__RDY  out  1  table accepts writes.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN; reset enters INIT with the clear pointer at 0.
REQ-018 In INIT, each cycle SHALL write 0 to table[ptr] and increment ptr; when ptr = 2^AWIDTH-1 is written, the next state SHALL be RUN, giving exactly 2^AWIDTH INIT cycles.
REQ-019 ifc$req__RDY and load$write__RDY SHALL be 0 in INIT.
REQ-020 In RUN, load$write__RDY SHALL be 1, and a write SHALL update table[addr] at the clock edge.
REQ-021 A request SHALL be accepted when ifc$req__ENA=1 and ifc$req__RDY=1; the table SHALL be read in the acceptance cycle.
REQ-022 A read and a write to the same address in the same cycle SHALL return the old value.
REQ-023 Read data SHALL traverse a LATENCY-stage valid/data pipeline and enter the response FIFO LATENCY cycles after acceptance, so ifc$resValue__RDY rises LATENCY cycles later at minimum.
REQ-024 Responses SHALL be returned strictly in request order.
REQ-025 The occupancy counter SHALL equal in-flight pipeline entries plus FIFO entries: +1 on accept, -1 on resAccept, unchanged when both occur.
REQ-026 ifc$req__RDY SHALL be (state=RUN) & (registered occupancy < DEPTH), with no combinational path from any __ENA input.
REQ-027 When full, a request SHALL NOT be accepted in the same cycle as a resAccept; acceptance resumes the following cycle.
REQ-028 ifc$resValue__RDY and ifc$resAccept__RDY SHALL both equal "FIFO not empty"; ifc$resValue SHALL be the FIFO head and SHALL be held stable until it is accepted.
REQ-029 The FIFO SHALL never overflow, because the occupancy bound guarantees space for every in-flight entry.
REQ-030 Enqueue into an empty FIFO and resAccept SHALL NOT collide, since resAccept requires a non-empty FIFO.
REQ-031 Simultaneous enqueue and dequeue SHALL be supported on a non-empty FIFO.
REQ-032 The counter and FIFO pointers SHALL wrap modulo their size without error.

Reset
REQ-033 While nRST=0: state=INIT, ptr=0, pipeline valids=0, FIFO empty, occupancy=0, and every __RDY output=0; ifc$resValue SHALL be 0.
REQ-034 Asserting reset mid-operation SHALL discard all in-flight and queued responses.
REQ-035 Table contents SHALL be re-cleared by INIT after every reset.

Verification
REQ-036 Release reset, hold all ENAs low -> both RDYs become 1 exactly 256 cycles later (AWIDTH=8); a request to key 0x55 then returns 0.
REQ-037 Write addr 0x12 = 0xDEADBEEF, then request v=0xFFFF0012 -> resValue=0xDEADBEEF with resValue__RDY asserted 2 cycles after accept.
REQ-038 Four back-to-back requests, no resAccept -> req__RDY=0 after the fourth; one resAccept -> req__RDY=1 the next cycle; the order of the four responses is preserved.
REQ-039 Same-cycle write 0x12=0x1 and request 0x12 (old value 0x7) -> response 0x7; the next request to 0x12 returns 0x1.
REQ-040 Reset pulse with 3 outstanding requests -> after reset, FIFO empty, resValue__RDY=0 and no stale response appears; INIT repeats.
REQ-041 Random ENA traffic with a scoreboard over 10k cycles -> no response is lost, duplicated, or reordered, and occupancy never exceeds 4.
